pwm_peripheral: RTL and testbench

//  Downstream consumer of the SPI register file: turns en_reg_out_*, en_reg_pwm_* and pwm_duty_cycle into
//  16 output pins. Each pin is forced low, driven static high, or driven by a shared 8-bit PWM waveform.

---
 rtl/pwm_pkg.sv | 6 +
 rtl/pwm_timebase.sv | 27 ++
 rtl/pwm_peripheral.sv | 45 ++++
 tb/tb_pwm_peripheral.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths and constants for the PWM peripheral
package pwm_pkg;
  localparam int NUM_CH = 16;
  localparam int PWM_CNT_W = 8;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler and 8-bit PWM count; tick per CLK_DIV clk, wrap on the 255->0 tick
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 3000
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 tick,
  output logic [PWM_CNT_W-1:0] pwm_cnt,
  output logic                 wrap
);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
  logic [PW-1:0] pre;
  assign tick = pre == LAST;
  assign wrap = tick && pwm_cnt == '1;
  always_ff @(posedge clk) begin
    if (rst) begin
      pre     <= '0;
      pwm_cnt <= '0;
    end else begin
      pre     <= tick ? '0 : pre + 1'b1;
      pwm_cnt <= pwm_cnt + PWM_CNT_W'(tick);
    end
  end
endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16 pins driven off, static high or from a shared PWM whose duty updates only at period wrap
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 3000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           en_reg_out_7_0,
  input  logic [7:0]           en_reg_out_15_8,
  input  logic [7:0]           en_reg_pwm_7_0,
  input  logic [7:0]           en_reg_pwm_15_8,
  input  logic [7:0]           pwm_duty_cycle,
  output logic [NUM_CH-1:0]    out,
  output logic                 period_start
);
  logic                 tick;
  logic                 wrap;
  logic                 pwm_hi;
  logic [PWM_CNT_W-1:0] pwm_cnt;
  logic [PWM_CNT_W-1:0] duty_shadow;
  logic [NUM_CH-1:0]    en_out;
  logic [NUM_CH-1:0]    en_pwm;
  pwm_timebase #(.CLK_DIV(CLK_DIV)) u_timebase (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .pwm_cnt(pwm_cnt),
    .wrap   (wrap)
  );
  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign pwm_hi = duty_shadow == DUTY_FULL || pwm_cnt < duty_shadow;
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_shadow  <= '0;
      period_start <= 1'b0;
      out          <= '0;
    end else begin
      if (tick && pwm_cnt == DUTY_FULL) duty_shadow <= pwm_duty_cycle;
      period_start <= wrap;
      out          <= en_out & (~en_pwm | {NUM_CH{pwm_hi}});
    end
  end
endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: scenario tasks plus a cycle-count reference model of the PWM peripheral
module tb_pwm_peripheral;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] eo = 16'hFFFF;
  logic [15:0] ep = 16'hFFFF;
  logic [7:0]  duty = 8'hFF;
  logic [15:0] out;
  logic        ps;
  int          errors = 0;
  int          checks = 0;
  int          k = 0;
  logic [7:0]  m_sh = 8'h00;
  logic [15:0] exp_out = 16'h0000;
  logic        exp_ps = 1'b0;
  pwm_peripheral #(.CLK_DIV(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .en_reg_out_7_0 (eo[7:0]),
    .en_reg_out_15_8(eo[15:8]),
    .en_reg_pwm_7_0 (ep[7:0]),
    .en_reg_pwm_15_8(ep[15:8]),
    .pwm_duty_cycle (duty),
    .out            (out),
    .period_start   (ps)
  );
  always #5 clk = ~clk;
  function automatic logic hi(input logic [7:0] d, input logic [7:0] c);
    return d == 8'hFF || c < d;
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      k       <= 0;
      m_sh    <= 8'h00;
      exp_out <= 16'h0000;
      exp_ps  <= 1'b0;
    end else begin
      exp_out <= eo & (~ep | {16{hi(m_sh, 8'((k / 4) % 256))}});
      exp_ps  <= (k + 1) % 1024 == 0;
      if ((k + 1) % 1024 == 0) m_sh <= duty;
      k <= k + 1;
    end
  end
  task automatic wait_ps(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 2100 && !ok) begin
      @(negedge clk);
      n++;
      ok = ps;
    end
  endtask
  task automatic test_reset;
    int n;
    rst = 1'b1; eo = 16'hFFFF; ep = 16'hFFFF; duty = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out !== 16'h0000 || ps !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold out=%h ps=%b want out=0000 ps=0", out, ps);
      end
    end
    rst = 1'b0;
    for (int p = 0; p < 2; p++) begin
      n = 0;
      while (n < 1100) begin
        @(negedge clk);
        n++;
        if (ps) break;
      end
      checks++;
      if (n !== 1024) begin
        errors++;
        $display("FAIL reset_first_period p=%0d got %0d cycles want 1024", p, n);
      end
    end
  endtask
  task automatic test_static;
    eo = 16'hA5C3; ep = 16'h0000;
    @(negedge clk);
    checks++;
    if (out !== 16'hA5C3) begin
      errors++;
      $display("FAIL static_latency out=%h want a5c3", out);
    end
    repeat (3072) begin
      @(negedge clk);
      checks++;
      if (out !== 16'hA5C3 || out !== exp_out) begin
        errors++;
        $display("FAIL static_hold out=%h want a5c3 model=%h", out, exp_out);
      end
    end
  endtask
  task automatic test_duty40;
    bit ok;
    int h;
    duty = 8'h40; eo = 16'hFFFF; ep = 16'hFFFF;
    wait_ps(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL duty40_wait no period_start seen want 1"); end
    for (int p = 0; p < 2; p++) begin
      h = 0;
      repeat (1024) begin
        @(negedge clk);
        if (out === 16'hFFFF) h++;
        checks++;
        if (out !== exp_out) begin
          errors++;
          $display("FAIL duty40_model out=%h want %h", out, exp_out);
        end
      end
      checks++;
      if (h !== 256) begin errors++; $display("FAIL duty40_high p=%0d got %0d want 256", p, h); end
    end
  endtask
  task automatic test_limits;
    bit ok;
    int h;
    duty = 8'h00;
    wait_ps(ok);
    h = 0;
    repeat (1024) begin
      @(negedge clk);
      if (out !== 16'h0000) h++;
    end
    checks++;
    if (!ok || h !== 0) begin errors++; $display("FAIL duty00_high ok=%b got %0d want 0", ok, h); end
    duty = 8'hFF;
    wait_ps(ok);
    h = 0;
    repeat (2048) begin
      @(negedge clk);
      if (out !== 16'hFFFF) h++;
    end
    checks++;
    if (!ok || h !== 0) begin errors++; $display("FAIL dutyff_low ok=%b got %0d want 0", ok, h); end
  endtask
  task automatic test_mid_write;
    bit ok;
    int h;
    duty = 8'h80;
    wait_ps(ok);
    h = 0;
    for (int i = 1; i <= 1024; i++) begin
      @(negedge clk);
      if (i == 40) duty = 8'h20;
      if (out === 16'hFFFF) h++;
    end
    checks++;
    if (!ok || h !== 512) begin errors++; $display("FAIL midwrite_cur ok=%b got %0d want 512", ok, h); end
    checks++;
    if (ps !== 1'b1) begin errors++; $display("FAIL midwrite_boundary ps=%b want 1", ps); end
    h = 0;
    repeat (1024) begin
      @(negedge clk);
      if (out === 16'hFFFF) h++;
    end
    checks++;
    if (h !== 128) begin errors++; $display("FAIL midwrite_next got %0d want 128", h); end
  endtask
  task automatic test_dominance_reset;
    bit ok;
    int bad;
    eo = 16'h00FF; ep = 16'hFFFF; duty = 8'hFF;
    wait_ps(ok);
    @(negedge clk);
    checks++;
    if (!ok || out !== 16'h00FF) begin errors++; $display("FAIL dominance ok=%b out=%h want 00ff", ok, out); end
    repeat (399) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out !== 16'h0000 || ps !== 1'b0) begin
      errors++;
      $display("FAIL midreset out=%h ps=%b want 0000 0", out, ps);
    end
    rst = 1'b0;
    bad = 0;
    for (int i = 1; i <= 1024; i++) begin
      @(negedge clk);
      if (out !== 16'h0000) bad++;
      if (i == 1024) begin
        checks++;
        if (ps !== 1'b1) begin errors++; $display("FAIL midreset_period ps=%b want 1", ps); end
      end
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL midreset_low got %0d nonzero cycles want 0", bad); end
    @(negedge clk);
    checks++;
    if (out !== 16'h00FF) begin errors++; $display("FAIL midreset_reload out=%h want 00ff", out); end
  endtask
  task automatic test_random;
    for (int it = 0; it < 40; it++) begin
      eo = 16'($urandom); ep = 16'($urandom); duty = 8'($urandom);
      if (it % 13 == 5) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
      repeat ($urandom_range(20, 200)) begin
        @(negedge clk);
        checks++;
        if (out !== exp_out || ps !== exp_ps) begin
          errors++;
          $display("FAIL random it=%0d out=%h ps=%b want %h %b", it, out, ps, exp_out, exp_ps);
        end
      end
    end
  endtask
  initial begin
    test_reset;
    test_static;
    test_duty40;
    test_limits;
    test_mid_write;
    test_dominance_reset;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
